combo_lock_sequencer: RTL

Transmitter side of the four-key hold-to-unlock combination lock. On a start request it drives four key lines in a programmed order, each key pressed cumulatively (earlier keys stay held), advancing every HOLD_TICKS prescaled ticks. It then waits for the lock's unlock indication and reports pass or fail. It sits between the board's test controller and the lock inputs, as an automated dialer and self-test driver.

---
 rtl/combo_lock_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/combo_lock_sequencer.sv
// combo_lock_sequencer
//   Automated dialer / self-test driver for the four-key hold-to-unlock lock.
//   On start it presses keys cumulatively in the order given by seq, adding
//   one key every HOLD_TICKS prescaled ticks. Once all four stages are held,
//   it waits up to TIMEOUT_TICKS ticks for unlock_in and then reports the
//   result.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   start     : request a sequence (sampled only when idle)
//   seq[7:0]  : key order; seq[2k+1:2k] is the key index for stage k
//   abort     : synchronous cancel back to idle, no done pulse
//   unlock_in : unlock indication from the lock (sampled only while waiting)
//   keys[3:0] : key drive lines, bit i = key i pressed
//   tick      : one-clk pulse at each prescaler wrap while busy
//   busy      : high while pressing or waiting
//   done      : one-clk pulse when a sequence completes
//   pass      : result of the last completed sequence
module combo_lock_sequencer #(
    parameter int unsigned PRESCALE_BITS = 14,
    parameter int unsigned HOLD_TICKS    = 12,
    parameter int unsigned TIMEOUT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] seq,
    input  logic       abort,
    input  logic       unlock_in,
    output logic [3:0] keys,
    output logic       tick,
    output logic       busy,
    output logic       done,
    output logic       pass
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]               state;
    logic [PRESCALE_BITS-1:0] presc;
    logic [7:0]               hold_cnt;
    logic [7:0]               tout_cnt;
    logic [1:0]               stage;
    logic [7:0]               seq_r;
    logic [1:0]               next_stage;
    logic [1:0]               next_key;

    function automatic logic [3:0] onehot(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

    assign next_stage = stage + 2'd1;
    assign next_key   = seq_r[{next_stage, 1'b0} +: 2];

    // busy is registered, so tick is a decode of registered state only.
    assign tick = busy && (presc == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            presc    <= '0;
            hold_cnt <= '0;
            tout_cnt <= '0;
            stage    <= '0;
            seq_r    <= '0;
            keys     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                presc    <= '0;
                hold_cnt <= '0;
                tout_cnt <= '0;
                stage    <= '0;
                keys     <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            seq_r    <= seq;
                            presc    <= '0;
                            hold_cnt <= '0;
                            tout_cnt <= '0;
                            stage    <= '0;
                            pass     <= 1'b0;
                            keys     <= onehot(seq[1:0]);
                            busy     <= 1'b1;
                            state    <= ST_PRESS;
                        end
                    end
                    ST_PRESS: begin
                        presc <= presc + 1'b1;
                        if (tick) begin
                            if (hold_cnt == 8'(HOLD_TICKS - 1)) begin
                                hold_cnt <= '0;
                                if (stage == 2'd3) begin
                                    state <= ST_WAIT;
                                end else begin
                                    stage <= next_stage;
                                    keys  <= keys | onehot(next_key);
                                end
                            end else begin
                                hold_cnt <= hold_cnt + 8'd1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        presc <= presc + 1'b1;
                        // Unlock is checked first so it wins over a
                        // coincident timeout tick.
                        if (unlock_in) begin
                            pass  <= 1'b1;
                            done  <= 1'b1;
                            keys  <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (tick) begin
                            if (tout_cnt == 8'(TIMEOUT_TICKS - 1)) begin
                                pass  <= 1'b0;
                                done  <= 1'b1;
                                keys  <= '0;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                tout_cnt <= tout_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        keys  <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
